irq_ctrl: RTL
=============

# irq_ctrl

Machine-level interrupt controller between the interrupt sources (the timer and the external interrupt pin) and the pipeline CPU's trap logic. It latches requests into pending bits, applies enables, and selects one cause by fixed priority. It presents that cause to the core through a valid/take handshake and tracks the in-service state until `mret` retires. It is also the responder for the timer's level-request/ack protocol: it returns the single-cycle `timer_int_ack` that lets the timer drop its request and restart counting.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop stages on `external_int` before edge detection; minimum 2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous and active-low.
- `timer_int`  in  1  level request from the timer; held high until acknowledged.
- `timer_int_ack`  out  1  one-cycle acknowledge pulse to the timer.
- `external_int`  in  1  asynchronous external request; a rising edge is the event.
- `global_ie`  in  1  mstatus.MIE.
- `mie_mtie`  in  1  timer enable, mie[7].
- `mie_meie`  in  1  external enable, mie[11].
- `irq_valid`  out  1  interrupt request to the core.
- `irq_cause`  out  32  mcause value; stable while `irq_valid` is high.
- `irq_take`  in  1  core enters the trap this cycle (one-cycle strobe).
- `irq_done`  in  1  `mret` retired (one-cycle strobe).
- `mip_bits`  out  2  {`ext_pend`, `tmr_pend`}, for CSR read of mip[11] and mip[7].
- `in_service`  out  1  high while a handler is active.

## Operation
**Timer pending**
- `tmr_pend` = `timer_int` & ~`ack_block`.
- `ack_block` is set in the cycle `timer_int_ack` pulses.
- `ack_block` clears in the first cycle `timer_int` is sampled low.
- Effect: a stale high level in the cycle after the ack can never re-trigger.

**External pending**
- `external_int` passes through the `SYNC_STAGES` synchronizer, then a rising-edge detector.
- The detected edge sets `ext_pend`.
- `ext_pend` clears only when an external interrupt is taken.
- If an edge and a take of the external cause occur in the same cycle, set wins and the new event stays pending.

**Selection**
- `ext_eligible` = `ext_pend` & `mie_meie`; `tmr_eligible` = `tmr_pend` & `mie_mtie`.
- Priority: external over timer.
- Causes: 32'h8000000B for external, 32'h80000007 for timer.

**FSM (IDLE, REQ, SERVICE)**
- IDLE -> REQ when `global_ie` & (any eligible). The cause is latched into `irq_cause` on this transition.
- REQ -> SERVICE on `irq_take`:
  - latched cause external: clear `ext_pend`;
  - latched cause timer: register `timer_int_ack` for the next cycle.
- REQ -> IDLE when `global_ie` drops or the latched cause is no longer eligible, with `irq_take` low.
- If `irq_take` arrives in that same cycle, take wins.
- No cause change while in REQ. A higher-priority arrival waits for the next IDLE.
- SERVICE -> IDLE on `irq_done`. No nesting.
- Strobes are ignored outside their state: `irq_take` outside REQ, `irq_done` outside SERVICE.

**Outputs**
- `irq_valid` = (state == REQ).
- `in_service` = (state == SERVICE).
- `mip_bits` reflects the raw pending bits, before enables.

**Reset (async)**
- State IDLE; `irq_valid` 0; `irq_cause` 0; `timer_int_ack` 0.
- `ext_pend`, `ack_block` and synchronizer flops all 0; `in_service` 0; `mip_bits` 2'b00.
- A reset mid-handshake abandons it; no ack is issued.
- A `timer_int` still high after reset re-requests normally.

## Timing
- All outputs are registered. `mip_bits` is the exception: bit 1 is a flop, bit 0 is `timer_int` gated by the `ack_block` flop.
- Timer: `timer_int` rises before edge N; `irq_valid` is high in cycle N+1 (enables set, IDLE).
- External: rising edge sampled at edge N sets `ext_pend` after `SYNC_STAGES`+1 edges; `irq_valid` follows one cycle later.
- Take at edge T (timer cause):
  - `timer_int_ack` high for exactly cycle T+1;
  - `irq_valid` low from T+1; `in_service` high from T+1.
- `irq_done` at edge D: IDLE from D+1; earliest new `irq_valid` is at D+2.
- `timer_int_ack` never pulses twice for one timer request.

## Test plan
- Timer path, all enables 1, `timer_int` raised → `irq_valid`=1, `irq_cause`=0x80000007 next cycle. Then `irq_take` → one-cycle `timer_int_ack`; `timer_int` still high one extra cycle → no second request.
- `external_int` pulse held for 4 cycles, with `timer_int` high at the same time → cause 0x8000000B first. After `irq_done` → timer request follows, with cause 0x80000007.
- `global_ie` dropped in REQ with no take → `irq_valid` falls next cycle. `global_ie` dropped in the same cycle as `irq_take` → SERVICE entered, ack issued.
- `mie_mtie`=0 with `timer_int` high → `mip_bits`=2'b01 and `irq_valid` stays 0. Enable → request within 1 cycle.
- Second external edge during SERVICE → `ext_pend` stays 1. `irq_done` → `irq_valid` at D+2.
- `rstn` pulsed low in REQ → all outputs 0 immediately. Release with `timer_int` high → `irq_valid` re-asserts one cycle later.

Source files
------------

// File: rtl/irq_ctrl.sv
// Machine-level interrupt controller: latches timer/external requests, selects one cause by
// fixed priority, runs the valid/take handshake and the timer level-request/ack protocol.
module irq_ctrl #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        timer_int,
  output logic        timer_int_ack,
  input  logic        external_int,
  input  logic        global_ie,
  input  logic        mie_mtie,
  input  logic        mie_meie,
  output logic        irq_valid,
  output logic [31:0] irq_cause,
  input  logic        irq_take,
  input  logic        irq_done,
  output logic [1:0]  mip_bits,
  output logic        in_service
);

  localparam logic [31:0] CAUSE_EXT = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TMR = 32'h8000_0007;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ext_prev_q;
  logic                   ext_pend_q, ext_pend_d;
  logic                   ack_block_q, ack_block_d;
  logic                   ack_q, ack_d;
  logic                   cause_ext_q, cause_ext_d;
  logic [31:0]            cause_q, cause_d;

  logic ext_edge, tmr_pend, ext_elig, tmr_elig, latched_elig;

  assign ext_edge     = sync_q[SYNC_STAGES-1] & ~ext_prev_q;
  assign tmr_pend     = timer_int & ~ack_block_q;
  assign ext_elig     = ext_pend_q & mie_meie;
  assign tmr_elig     = tmr_pend & mie_mtie;
  assign latched_elig = cause_ext_q ? ext_elig : tmr_elig;

  always_comb begin
    state_d     = state_q;
    ext_pend_d  = ext_pend_q;
    ack_block_d = ack_block_q;
    ack_d       = 1'b0;
    cause_ext_d = cause_ext_q;
    cause_d     = cause_q;
    if (!timer_int) ack_block_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (global_ie && (ext_elig || tmr_elig)) begin
          state_d     = REQ;
          cause_ext_d = ext_elig;
          cause_d     = ext_elig ? CAUSE_EXT : CAUSE_TMR;
        end
      end
      REQ: begin
        if (irq_take) begin
          state_d = SERVICE;
          if (cause_ext_q) begin
            ext_pend_d = 1'b0;
          end else begin
            // Block the stale timer level from the ack cycle until the timer drops it.
            ack_d       = 1'b1;
            ack_block_d = 1'b1;
          end
        end else if (!global_ie || !latched_elig) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (irq_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new edge in the same cycle as the external take stays pending.
    if (ext_edge) ext_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      ext_prev_q  <= 1'b0;
      ext_pend_q  <= 1'b0;
      ack_block_q <= 1'b0;
      ack_q       <= 1'b0;
      cause_ext_q <= 1'b0;
      cause_q     <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], external_int};
      ext_prev_q  <= sync_q[SYNC_STAGES-1];
      ext_pend_q  <= ext_pend_d;
      ack_block_q <= ack_block_d;
      ack_q       <= ack_d;
      cause_ext_q <= cause_ext_d;
      cause_q     <= cause_d;
    end
  end

  assign timer_int_ack = ack_q;
  assign irq_valid     = (state_q == REQ);
  assign in_service    = (state_q == SERVICE);
  assign irq_cause     = cause_q;
  assign mip_bits      = {ext_pend_q, tmr_pend & rstn};

endmodule
